// File: rtl/conv_pkg.sv
// Shared constants for the convolution accumulate sequencer: FSM encoding and datapath widths.
package conv_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  localparam int KERNEL_TERMS = 9;
  localparam int OUT_PIXELS   = 4;
  localparam int PIX_W        = 4;
  localparam int PROD_W       = 8;

  // Index width that stays legal when a count of one would otherwise give zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eight_bit_adder.sv
// Plain unsigned 8-bit ripple adder with carry in and carry out.
module eight_bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  assign sum    = w_full[7:0];
  assign cout   = w_full[8];

endmodule

// File: rtl/conv_accum_sequencer.sv
// Accumulates NUM_TERMS product terms per output pixel through one shared adder and
// hands each finished pixel out over a valid/ready port.
module conv_accum_sequencer
  import conv_pkg::*;
#(
  parameter int NUM_TERMS   = KERNEL_TERMS,
  parameter int NUM_OUTPUTS = OUT_PIXELS,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  input  logic                                prod_valid,
  output logic                                prod_ready,
  input  logic [PROD_W-1:0]                   prod_data,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [PROD_W-1:0]                   res_data,
  output logic                                res_ovf,
  output logic [idx_width(NUM_OUTPUTS)-1:0]   res_idx,
  output logic                                done,
  output logic [1:0]                          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and payload is held stable while valid && !ready.

  localparam int TERM_W = idx_width(NUM_TERMS);
  localparam int IDX_W  = idx_width(NUM_OUTPUTS);

  logic [1:0]        r_state;
  logic [PROD_W-1:0] r_acc;
  logic              r_ovf;
  logic [TERM_W-1:0] r_term_cnt;
  logic [IDX_W-1:0]  r_out_cnt;
  logic              r_done;

  logic [PROD_W-1:0] w_sum;
  logic              w_cout;
  logic [PROD_W-1:0] w_acc_next;
  logic              w_prod_hs;
  logic              w_res_hs;
  logic              w_last_term;
  logic              w_last_pix;

  eight_bit_adder u_add (
    .a    (r_acc),
    .b    (prod_data),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_prod_hs   = (r_state == S_ACCUM) && prod_valid;
  assign w_res_hs    = (r_state == S_OUTPUT) && res_ready;
  assign w_last_term = (r_term_cnt == TERM_W'(NUM_TERMS - 1));
  assign w_last_pix  = (r_out_cnt == IDX_W'(NUM_OUTPUTS - 1));

  // Once a pixel has overflowed in saturate mode it stays pinned at full scale.
  assign w_acc_next = (SATURATE && (w_cout || r_ovf)) ? {PROD_W{1'b1}} : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_term_cnt <= '0;
      r_out_cnt  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_term_cnt <= '0;
            r_out_cnt  <= '0;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_prod_hs) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_cout;
            if (w_last_term) begin
              r_term_cnt <= '0;
              r_state    <= S_OUTPUT;
            end else begin
              r_term_cnt <= r_term_cnt + TERM_W'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (w_res_hs) begin
            if (w_last_pix) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_out_cnt <= r_out_cnt + IDX_W'(1);
              r_acc     <= '0;
              r_ovf     <= 1'b0;
              r_state   <= S_ACCUM;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign prod_ready = (r_state == S_ACCUM);
  assign res_valid  = (r_state == S_OUTPUT);
  assign res_data   = res_valid ? r_acc : '0;
  assign res_ovf    = res_valid & r_ovf;
  assign res_idx    = res_valid ? r_out_cnt : '0;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_accum_sequencer.sv
// Directed bench for conv_accum_sequencer: wrap and saturate instances driven in lockstep.
module tb_conv_accum_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       prod_valid;
  logic [7:0] prod_data;
  logic       res_ready;

  logic       busy, prod_ready, res_valid, res_ovf, done;
  logic [7:0] res_data;
  logic [1:0] res_idx;
  logic [1:0] dbg_state;

  logic       busy_s, prod_ready_s, res_valid_s, res_ovf_s, done_s;
  logic [7:0] res_data_s;
  logic [1:0] res_idx_s;
  logic [1:0] dbg_state_s;

  int checks = 0;
  int errors = 0;
  int res_cnt = 0;
  int done_cnt = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  exp_sat_q[$];

  typedef struct {
    logic [7:0] val;
    logic [7:0] exp_wrap;
    logic       exp_ovf;
    logic [7:0] exp_sat;
    bit         gaps;
    int         hold;
    bit         poke;
  } vec_t;

  vec_t tbl[12];

  conv_accum_sequencer #(.NUM_TERMS(9), .NUM_OUTPUTS(4), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .res_idx(res_idx), .done(done), .dbg_state(dbg_state)
  );

  conv_accum_sequencer #(.NUM_TERMS(9), .NUM_OUTPUTS(4), .SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_s),
    .prod_valid(prod_valid), .prod_ready(prod_ready_s), .prod_data(prod_data),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s),
    .res_ovf(res_ovf_s), .res_idx(res_idx_s), .done(done_s), .dbg_state(dbg_state_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard: every accepted pixel is matched against the expected queue
  always @(posedge clk) begin
    if (res_valid && res_ready) begin
      res_cnt++;
      if (exp_q.size() == 0 || exp_sat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", res_data);
      end else begin
        logic [10:0] e;
        logic [7:0]  es;
        e  = exp_q.pop_front();
        es = exp_sat_q.pop_front();
        check("res_data", {24'd0, res_data}, {24'd0, e[7:0]});
        check("res_ovf", {31'd0, res_ovf}, {31'd0, e[8]});
        check("res_idx", {30'd0, res_idx}, {30'd0, e[10:9]});
        check("res_data_sat", {24'd0, res_data_s}, {24'd0, es});
        check("res_ovf_sat", {31'd0, res_ovf_s}, {31'd0, e[8]});
        check("res_valid_sat", {31'd0, res_valid_s}, 32'd1);
      end
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic send(input logic [7:0] v);
    int b;
    b = 0;
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = v;
    while (!prod_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!prod_ready) begin
      checks++;
      errors++;
      $display("FAIL prod_ready_wait actual=0 required=1");
    end
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_pixel(input int idx, input vec_t v);
    logic [1:0] idx2;
    idx2 = 2'(idx);
    exp_q.push_back({idx2, v.exp_ovf, v.exp_wrap});
    exp_sat_q.push_back(v.exp_sat);
    for (int t = 0; t < 9; t++) begin
      if (v.gaps) begin
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(negedge clk);
          prod_valid = 1'b0;
        end
      end
      if (v.poke && t == 3) begin
        @(negedge clk);
        prod_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send(v.val);
    end
    // result appears the cycle after the last product; keep offering a stray product
    @(negedge clk);
    prod_valid = 1'b1;
    prod_data  = 8'hAA;
    check("latency_res_valid", {31'd0, res_valid}, 32'd1);
    check("output_prod_ready", {31'd0, prod_ready}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      if (v.poke && h == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("hold_res_data", {24'd0, res_data}, {24'd0, v.exp_wrap});
      check("hold_res_idx", {30'd0, res_idx}, {30'd0, idx2});
      check("hold_prod_ready", {31'd0, prod_ready}, 32'd0);
      check("hold_res_valid", {31'd0, res_valid}, 32'd1);
    end
    prod_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_frame(input int base);
    int r0, d0;
    r0 = res_cnt;
    d0 = done_cnt;
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int p = 0; p < 4; p++) run_pixel(p, tbl[base + p]);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("results_per_frame", res_cnt - r0, 32'd4);
    check("done_per_frame", done_cnt - d0, 32'd1);
  endtask

  initial begin
    // basic: 9 x 0x05 = 0x2D
    for (int i = 0; i < 4; i++) tbl[i] = '{8'h05, 8'h2D, 1'b0, 8'h2D, 1'b0, 0, 1'b0};
    // overflow patterns, gaps and backpressure
    tbl[4]  = '{8'h40, 8'h40, 1'b1, 8'hFF, 1'b0, 0, 1'b0};
    tbl[5]  = '{8'h01, 8'h09, 1'b0, 8'h09, 1'b1, 5, 1'b0};
    tbl[6]  = '{8'hFF, 8'hF7, 1'b1, 8'hFF, 1'b1, 2, 1'b0};
    tbl[7]  = '{8'h12, 8'hA2, 1'b0, 8'hA2, 1'b0, 1, 1'b0};
    // start pulses while busy must be ignored
    tbl[8]  = '{8'h03, 8'h1B, 1'b0, 8'h1B, 1'b0, 2, 1'b1};
    tbl[9]  = '{8'h1C, 8'hFC, 1'b0, 8'hFC, 1'b1, 3, 1'b1};
    tbl[10] = '{8'h1D, 8'h05, 1'b1, 8'hFF, 1'b0, 2, 1'b1};
    tbl[11] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    prod_valid = 1'b0;
    prod_data = 8'h00;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_prod_ready", {31'd0, prod_ready}, 32'd0);
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", {31'd0, busy}, 32'd0);

    run_frame(0);
    run_frame(4);
    run_frame(8);

    // reset mid-accumulation after 3 products
    pulse_start();
    for (int t = 0; t < 3; t++) send(8'h77);
    @(negedge clk);
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_prod_ready", {31'd0, prod_ready}, 32'd0);
    check("midreset_res_valid", {31'd0, res_valid}, 32'd0);
    check("midreset_res_data", {24'd0, res_data}, 32'd0);
    check("midreset_res_ovf", {31'd0, res_ovf}, 32'd0);
    check("midreset_res_idx", {30'd0, res_idx}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0);

    // start coinciding with done: honoured immediately
    pulse_start();
    for (int p = 0; p < 4; p++) run_pixel(p, tbl[p]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_busy", {31'd0, busy}, 32'd1);
    check("start_on_done_ready", {31'd0, prod_ready}, 32'd1);
    for (int p = 0; p < 4; p++) run_pixel(p, tbl[4 + p]);
    @(negedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
